// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, branch redirect, and the
// valid/ready link to decode. master = fetch_sequencer, slave = memory/decode side.
interface fetch_sequencer_if #(
  parameter int WORD = 32
);
  logic              imem_req;
  logic [WORD-1:0]   imem_addr;
  logic              imem_ack;
  logic [WORD-1:0]   imem_rdata;
  logic              redirect;
  logic [WORD-1:0]   redirect_base;
  logic [WORD/2-1:0] redirect_imm;
  logic              if_valid;
  logic              if_ready;
  logic [WORD-1:0]   if_instr;
  logic [WORD-1:0]   if_pc;
  logic [WORD-1:0]   if_npc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_base, redirect_imm,
    output if_valid,
    input  if_ready,
    output if_instr, if_pc, if_npc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_base, redirect_imm,
    input  if_valid,
    output if_ready,
    input  if_instr, if_pc, if_npc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem read per fetch, hands words to decode.
// Optional perf counters (perf_fetches/perf_squashes) enabled by FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
  parameter int              WORD     = 32,
  parameter logic [WORD-1:0] RESET_PC = WORD'(32'h0040_0000)
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_SEQ_PERF_EN
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_squashes,
`endif
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0] ipc_q, ipc_d;
  logic [WORD-1:0] inpc_q, inpc_d;

  logic [WORD-1:0] imm_sext, target, pc_inc;
  logic            ack, redir, hs;

  assign imm_sext = {{(WORD/2){bus.redirect_imm[WORD/2-1]}}, bus.redirect_imm};
  assign target   = bus.redirect_base + (imm_sext << 2);
  assign pc_inc   = pc_q + WORD'(4);
  assign ack      = bus.imem_ack;
  assign redir    = bus.redirect;
  assign hs       = valid_q && bus.if_ready;

  // State and PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state / next PC; acks outside REQ and DRAIN fall through untouched
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir) pc_d = target;
      end
      REQ: begin
        if (redir) begin
          pc_d    = target;
          state_d = ack ? REQ : DRAIN;
        end else if (ack) begin
          pc_d    = pc_inc;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = target;
          state_d = REQ;
        end else if (hs) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (redir) pc_d = target;
        if (ack)   state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state. DRAIN keeps the old
  // address on the bus, since a request is never withdrawn before its ack.
  always_comb begin
    req_d   = (state_d == REQ) || (state_d == DRAIN);
    addr_d  = (state_d == REQ) ? pc_d : addr_q;
    valid_d = (state_d == HOLD);
    instr_d = instr_q;
    ipc_d   = ipc_q;
    inpc_d  = inpc_q;
    if (state_q == REQ && ack && !redir) begin
      instr_d = bus.imem_rdata;
      ipc_d   = pc_q;
      inpc_d  = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      inpc_q  <= '0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      inpc_q  <= inpc_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;
  assign bus.if_npc    = inpc_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] fetches_q, squashes_q;
  logic        squash;

  // A word is lost when HOLD is squashed or an ack lands under a redirect/drain
  assign squash = (state_q == HOLD  && redir && !hs) ||
                  (state_q == REQ   && ack   && redir) ||
                  (state_q == DRAIN && ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetches_q  <= '0;
      squashes_q <= '0;
    end else begin
      if (hs)     fetches_q  <= fetches_q + 32'd1;
      if (squash) squashes_q <= squashes_q + 32'd1;
    end
  end

  assign perf_fetches  = fetches_q;
  assign perf_squashes = squashes_q;
`else
  // Counters not built; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: delivered words are queued when acked
// and checked at the decode handshake; per-scenario tasks check control outputs.
module tb_fetch_sequencer;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.WORD(32)) bus ();
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetches, perf_squashes;
`endif

  fetch_sequencer #(.WORD(32), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef FETCH_SEQ_PERF_EN
    .perf_fetches  (perf_fetches),
    .perf_squashes (perf_squashes),
`endif
    .bus           (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Decode-side scoreboard: every handshake must match the oldest queued word
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.if_valid && bus.if_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got instr=%h pc=%h exp no delivery", bus.if_instr, bus.if_pc);
      end else begin
        e = sb.pop_front();
        if ({bus.if_instr, bus.if_pc, bus.if_npc} !== {e.instr, e.pc, e.npc}) begin
          errors++;
          $display("FAIL sb_word got %h/%h/%h exp %h/%h/%h", bus.if_instr, bus.if_pc, bus.if_npc,
                   e.instr, e.pc, e.npc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.redirect      = 1'b0;
    bus.redirect_base = '0;
    bus.redirect_imm  = '0;
    bus.if_ready      = 1'b0;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr; e.pc = pc; e.npc = pc + 32'd4;
    sb.push_back(e);
  endtask

  // Leaves the DUT in REQ at RESET_PC (one IDLE cycle after release)
  task automatic do_reset();
    idle_inputs();
    sb.delete();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", bus.imem_req); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", bus.if_valid); end
    checks++; if ({bus.if_instr, bus.if_pc, bus.if_npc} !== 96'd0) begin errors++; $display("FAIL rst_payload got %h/%h/%h exp 0", bus.if_instr, bus.if_pc, bus.if_npc); end
    checks++; if (bus.imem_addr !== RPC) begin errors++; $display("FAIL rst_addr got %h exp %h", bus.imem_addr, RPC); end
`ifdef FETCH_SEQ_PERF_EN
    checks++; if ({perf_fetches, perf_squashes} !== 64'd0) begin errors++; $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_fetches, perf_squashes); end
`endif
    rst = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin errors++; $display("FAIL rst_first_req got %0b@%h exp 1@%h", bus.imem_req, bus.imem_addr, RPC); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin errors++; $display("FAIL basic_hold_addr%0d got %0b@%h exp 1@%h", i, bus.imem_req, bus.imem_addr, RPC); end
      if (i < 2) step();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2408_0005; bus.if_ready = 1'b1;
    push(32'h2408_0005, RPC);
    step();
    bus.imem_ack = 1'b0;
    checks++; if (bus.if_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL basic_valid got v=%0b r=%0b exp v=1 r=0", bus.if_valid, bus.imem_req); end
    checks++; if (bus.if_instr !== 32'h2408_0005 || bus.if_npc !== 32'h0040_0004) begin errors++; $display("FAIL basic_payload got %h/%h exp 24080005/00400004", bus.if_instr, bus.if_npc); end
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL basic_next_addr got %0b@%h exp 1@00400004", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_hold_stall();
    do_reset();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8C09_0010;
    push(32'h8C09_0010, RPC);
    step();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.if_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.if_instr !== 32'h8C09_0010 || bus.if_pc !== RPC) begin
        errors++; $display("FAIL stall_cyc%0d got v=%0b r=%0b %h@%h exp v=1 r=0 8c090010@%h", i, bus.if_valid, bus.imem_req, bus.if_instr, bus.if_pc, RPC);
      end
      step();
    end
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0004 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %0b@%h v=%0b exp 1@00400004 v=0", bus.imem_req, bus.imem_addr, bus.if_valid); end
`ifdef FETCH_SEQ_PERF_EN
    checks++; if (perf_fetches !== 32'd1) begin errors++; $display("FAIL stall_perf_fetch got %0d exp 1", perf_fetches); end
`endif
  endtask

  task automatic test_redirect_hold();
    do_reset();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack = 1'b0;
    bus.redirect = 1'b1; bus.redirect_base = 32'h0040_0010; bus.redirect_imm = 16'hFFFC;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rhold_target got v=%0b %0b@%h exp v=0 1@00400000", bus.if_valid, bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_1111; bus.if_ready = 1'b1;
    push(32'h0000_1111, 32'h0040_0000);
    step();
    bus.imem_ack = 1'b0;
    step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rhold_delivery got %0d pending exp 0", sb.size()); end
`ifdef FETCH_SEQ_PERF_EN
    checks++; if (perf_fetches !== 32'd1 || perf_squashes !== 32'd1) begin errors++; $display("FAIL rhold_perf got %0d/%0d exp 1/1", perf_fetches, perf_squashes); end
`endif
  endtask

  task automatic test_redirect_req();
    do_reset();
    bus.redirect = 1'b1; bus.redirect_base = 32'h0000_1000; bus.redirect_imm = 16'h0000;
    step();
    // second redirect while draining must replace the first target
    bus.redirect_base = 32'h0040_0008; bus.redirect_imm = 16'h7FFF;
    step();
    bus.redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC || bus.if_valid !== 1'b0) begin errors++; $display("FAIL rreq_drain%0d got %0b@%h v=%0b exp 1@%h v=0", i, bus.imem_req, bus.imem_addr, bus.if_valid, RPC); end
      step();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0; bus.if_ready = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0042_0004) begin errors++; $display("FAIL rreq_target got v=%0b %0b@%h exp v=0 1@00420004", bus.if_valid, bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rreq_no_valid got %0b exp 0", bus.if_valid); end
`ifdef FETCH_SEQ_PERF_EN
    checks++; if (perf_fetches !== 32'd0 || perf_squashes !== 32'd1) begin errors++; $display("FAIL rreq_perf got %0d/%0d exp 0/1", perf_fetches, perf_squashes); end
`endif
  endtask

  task automatic test_redirect_ack();
    do_reset();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678; bus.if_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_base = 32'h0000_0000; bus.redirect_imm = 16'h8000;
    step();
    bus.imem_ack = 1'b0; bus.redirect = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFE_0000) begin errors++; $display("FAIL rack_target got v=%0b %0b@%h exp v=0 1@fffe0000", bus.if_valid, bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hCAFE_0001;
    push(32'hCAFE_0001, 32'hFFFE_0000);
    step();
    bus.imem_ack = 1'b0;
    step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rack_delivery got %0d pending exp 0", sb.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    // target 4 + (-2<<2) wraps below zero to 0xFFFF_FFFC
    bus.redirect = 1'b1; bus.redirect_base = 32'h0000_0004; bus.redirect_imm = 16'hFFFE;
    bus.imem_ack = 1'b1; bus.if_ready = 1'b1;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got %h exp fffffffc", bus.imem_addr); end
    bus.imem_rdata = 32'h0BAD_F00D;
    push(32'h0BAD_F00D, 32'hFFFF_FFFC);
    step();
    bus.imem_ack = 1'b0;
    checks++; if (bus.if_npc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_npc got %h exp 00000000", bus.if_npc); end
    step();
    checks++; if (bus.imem_addr !== 32'h0000_0000 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next got %0b@%h exp 1@00000000", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc, d;
    do_reset();
    bus.if_ready = 1'b1;
    pc = RPC;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      bus.imem_ack = 1'b1; bus.imem_rdata = d;
      push(d, pc);
      step();
      // a stray ack during HOLD must be ignored
      bus.imem_ack = (k == 2); bus.imem_rdata = ~d;
      step();
      bus.imem_ack = 1'b0;
      pc = pc + 32'd4;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc) begin errors++; $display("FAIL b2b_addr%0d got %0b@%h exp 1@%h", k, bus.imem_req, bus.imem_addr, pc); end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_delivery got %0d pending exp 0", sb.size()); end
  endtask

  task automatic test_reset_drain();
    do_reset();
    bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_base = 32'h0000_2000; bus.redirect_imm = 16'h0000;
    step();
    bus.imem_ack = 1'b0; bus.redirect_base = 32'h0000_3000;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_2000) begin errors++; $display("FAIL rdrain_pre got %0b@%h exp 1@00002000", bus.imem_req, bus.imem_addr); end
`ifdef FETCH_SEQ_PERF_EN
    checks++; if (perf_squashes !== 32'd1) begin errors++; $display("FAIL rdrain_pre_perf got %0d exp 1", perf_squashes); end
`endif
    rst = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== RPC) begin errors++; $display("FAIL rdrain_ctl got r=%0b v=%0b %h exp 0 0 %h", bus.imem_req, bus.if_valid, bus.imem_addr, RPC); end
    checks++; if ({bus.if_instr, bus.if_pc, bus.if_npc} !== 96'd0) begin errors++; $display("FAIL rdrain_payload got %h/%h/%h exp 0", bus.if_instr, bus.if_pc, bus.if_npc); end
`ifdef FETCH_SEQ_PERF_EN
    checks++; if ({perf_fetches, perf_squashes} !== 64'd0) begin errors++; $display("FAIL rdrain_perf got %0d/%0d exp 0/0", perf_fetches, perf_squashes); end
`endif
    rst = 1'b0;
    step(); step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin errors++; $display("FAIL rdrain_restart got %0b@%h exp 1@%h", bus.imem_req, bus.imem_addr, RPC); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_req();
    test_redirect_ack();
    test_wrap();
    test_back_to_back();
    test_reset_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d pending exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the 1_fetch stage: owns the PC, issues one instruction-memory read per fetch over a req/ack handshake, and presents the fetched word to decode over a valid/ready handshake.
- Computes branch redirect targets internally: sign-extends the 16-bit immediate, shifts it left 2, and adds it to the supplied base.
- Sits between instruction memory and the IF/ID boundary, driven by the design-wide clock `clk`.

Parameters:
- WORD, `WORD (32): datapath width; immediate width is WORD/2.
- RESET_PC, 32'h0040_0000: PC loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  WORD  read address; equals current PC.
- imem_ack  input  1  read complete; imem_rdata valid this cycle.
- imem_rdata  input  WORD  instruction word.
- redirect  input  1  one-cycle pulse: taken branch.
- redirect_base  input  WORD  PC+4 of the branch instruction.
- redirect_imm  input  WORD/2  raw 16-bit branch offset.
- if_valid  output  1  if_instr/if_pc/if_npc valid.
- if_ready  input  1  decode accepts this cycle.
- if_instr  output  WORD  fetched instruction.
- if_pc  output  WORD  address of if_instr.
- if_npc  output  WORD  if_pc + 4.

Behaviour:
- Reset (rst=1 at a rising edge):
  - pc=RESET_PC; state=IDLE.
  - imem_req=0; if_valid=0; if_instr=0; if_pc=0; if_npc=0; imem_addr=RESET_PC.
  - Reset asserted in any state aborts that state. Any outstanding memory transaction is abandoned; memory must tolerate req dropping.
- All outputs are registered.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: the first cycle after reset; go to REQ.
- REQ:
  - imem_req=1; imem_addr=pc.
  - Both are held stable until imem_ack.
  - On ack: if_instr<=imem_rdata; if_pc<=pc; if_npc<=pc+4; pc<=pc+4; if_valid<=1; go to HOLD.
- HOLD:
  - if_valid=1, imem_req=0, payload stable.
  - On if_valid&&if_ready: if_valid<=0; go to REQ.
  - Minimum loop: ack at cycle n, if_valid at n+1, handshake at n+1, imem_req at n+2.
- Redirect target:
  - target = redirect_base + ({{WORD/2{imm[15]}}, imm} << 2).
  - Computed modulo 2^WORD; wrap-around is legal and not flagged.
- Redirect in REQ without ack: pc<=target; go to DRAIN. The request stays asserted at the old address, because a req is never withdrawn before ack.
- Redirect in REQ with ack in the same cycle: data discarded; if_valid stays 0; pc<=target; go to REQ.
- DRAIN:
  - imem_req=1 at the old address until ack.
  - Data is discarded on ack; go to REQ at pc (the target).
  - A further redirect in DRAIN overwrites pc; the latest target wins.
- Redirect in HOLD without handshake: if_valid<=0 (squash); pc<=target; go to REQ.
- Redirect in HOLD with handshake in the same cycle: the word counts as delivered; pc<=target; go to REQ.
- Redirect in IDLE: pc<=target; go to REQ.
- pc+4 wraps from 0xFFFF_FFFC to 0x0000_0000 silently.
- imem_ack outside REQ/DRAIN is ignored.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- When defined, two extra output ports are added:
  - perf_fetches (32): +1 per word delivered on the if_valid&&if_ready handshake.
  - perf_squashes (32): +1 per discarded word, i.e. a HOLD squash or a DRAIN/REQ ack discarded under redirect.
- Both counters reset to 0, wrap at 2^32, and increment at most once per cycle.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset release, imem_ack after 2 cycles with rdata=0x2408_0005, if_ready=1 -> imem_addr=0x0040_0000 held 3 cycles; if_instr=0x2408_0005, if_pc=0x0040_0000, if_npc=0x0040_0004; next imem_addr=0x0040_0004.
2. if_ready=0 for 5 cycles in HOLD -> if_valid stays 1, payload stable, imem_req=0; release -> next request at 0x0040_0004.
3. Redirect in HOLD, base=0x0040_0010, imm=16'hFFFC -> word squashed; next imem_addr=0x0040_0000.
4. Redirect in REQ before ack, base=0x0040_0008, imm=16'h7FFF -> old address held until ack, data discarded, if_valid=0; then imem_addr=0x0042_0004.
5. Redirect with ack in the same REQ cycle, base=0x0000_0000, imm=16'h8000 -> no if_valid; next imem_addr=0xFFFE_0000.
6. rst asserted mid-DRAIN -> next cycle all outputs at reset values, imem_addr=0x0040_0000; with FETCH_SEQ_PERF_EN defined, both counters read 0.
